// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, alu_decode control codes and the
// legality check applied to held operations.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  localparam logic [OPW-1:0] ALU_AND = 4'd0;
  localparam logic [OPW-1:0] ALU_OR  = 4'd1;
  localparam logic [OPW-1:0] ALU_ADD = 4'd2;
  localparam logic [OPW-1:0] ALU_SLL = 4'd3;
  localparam logic [OPW-1:0] ALU_SUB = 4'd6;
  localparam logic [OPW-1:0] ALU_XOR = 4'd7;
  localparam logic [OPW-1:0] ALU_SRL = 4'd8;

  function automatic logic alu_op_legal(input logic [OPW-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SLL,
      ALU_SUB, ALU_XOR, ALU_SRL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle around the shared ALU arbiter.
//   req_*      : two requesters (port 0 execute stage, port 1 address/branch unit)
//   alu_*      : control code / operands out to the ALU, result / zero flag back
//   rsp_*      : registered, owner-tagged response
// Modports: master = requesters + ALU side, slave = arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [OPW-1:0]  alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_err;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
           alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctl, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
           alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctl, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way arbiter producing a one-hot grant when en is high.
// Default build: round-robin; the pointer names the port that wins the next
// contested cycle and only moves on contested grants.
// ALU_ARB_FIXED_PRIO_EN: port 0 always wins, no pointer flop.
// Ports: clk, rst_n (async active-low), req[1:0], en, gnt[1:0].
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // winner was ptr, so the loser is ~ptr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ptr <= 1'b0;
    else if (en && (&req))  ptr <= ~ptr;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with valid/ready
// handshakes and holds the result in a single owner-tagged register.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave).
// Build option: ALU_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  logic [1:0]      grant;
  logic            consume;
  logic            can_accept;
  logic            op_legal;
  logic [1:0]      rsp_valid_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  // rsp_ready on the non-owner port is masked by rsp_valid
  assign consume    = |(rsp_valid_q & bus.rsp_ready);
  assign can_accept = ~(|rsp_valid_q) | consume;

  alu_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .en    (can_accept),
    .gnt   (grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    bus.alu_ctl = '0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    if (grant[0]) begin
      bus.alu_ctl = bus.req0_op;
      bus.alu_a   = bus.req0_a;
      bus.alu_b   = bus.req0_b;
    end else if (grant[1]) begin
      bus.alu_ctl = bus.req1_op;
      bus.alu_a   = bus.req1_a;
      bus.alu_b   = bus.req1_b;
    end
  end

  assign op_legal = alu_op_legal(bus.alu_ctl);

  // A grant overwrites the register even when the held response is consumed
  // on the same edge, which keeps throughput at one op per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (|grant) begin
      rsp_valid_q  <= grant;
      rsp_result_q <= op_legal ? bus.alu_result : '0;
      rsp_zero_q   <= op_legal ? bus.alu_zero : 1'b1;
      rsp_err_q    <= ~op_legal;
    end else if (consume) begin
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8};
  endfunction

  // Behavioural ALU; illegal codes yield junk so the arbiter must mask them.
  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a << b[4:0];
      4'd6:    return a - b;
      4'd7:    return a ^ b;
      4'd8:    return a >> b[4:0];
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    bus.alu_result = alu_calc(bus.alu_ctl, bus.alu_a, bus.alu_b);
    bus.alu_zero   = is_legal(bus.alu_ctl) && (alu_calc(bus.alu_ctl, bus.alu_a, bus.alu_b) == 32'd0);
  end

  // Reference model state
  int          m_owner = -1;
  logic [31:0] m_res;
  bit          m_zero, m_err;
  int          m_ptr = 0;

  logic [3:0]  st_op [2];
  logic [31:0] st_a  [2];
  logic [31:0] st_b  [2];

  task automatic model_reset();
    m_owner = -1; m_res = 0; m_zero = 0; m_err = 0; m_ptr = 0;
  endtask

  task automatic check_rsp();
    if (m_owner < 0) begin
      chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
    end else begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(2'b01 << m_owner));
      chk("rsp_result", 64'(bus.rsp_result), 64'(m_res));
      chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
      chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
    end
  endtask

  // One clock: at negedge check held response, apply inputs, check grant and
  // ALU drive, then advance the model across the rising edge.
  task automatic cycle(input logic [1:0] v, input logic [1:0] rr, output int g);
    bit can;
    logic [1:0] exp_rdy;
    @(negedge clk);
    check_rsp();
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req0_op = st_op[0]; bus.req0_a = st_a[0]; bus.req0_b = st_b[0];
    bus.req1_op = st_op[1]; bus.req1_a = st_a[1]; bus.req1_b = st_b[1];
    #1;
    can = (m_owner < 0) || rr[m_owner];
    g = -1;
    if (can) begin
      if (v == 2'b01) g = 0;
      else if (v == 2'b10) g = 1;
      else if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = m_ptr;
        m_ptr = 1 - m_ptr;
`endif
      end
    end
    exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("alu_ctl", 64'(bus.alu_ctl), (g < 0) ? 64'd0 : 64'(st_op[g]));
    chk("alu_a", 64'(bus.alu_a), (g < 0) ? 64'd0 : 64'(st_a[g]));
    chk("alu_b", 64'(bus.alu_b), (g < 0) ? 64'd0 : 64'(st_b[g]));
    @(posedge clk);
    if (g >= 0) begin
      m_owner = g;
      m_err   = !is_legal(st_op[g]);
      m_res   = m_err ? 32'd0 : alu_calc(st_op[g], st_a[g], st_b[g]);
      m_zero  = m_err ? 1'b1 : (m_res == 32'd0);
    end else if (can && m_owner >= 0) begin
      m_owner = -1;
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    st_op[p] = op; st_a[p] = a; st_b[p] = b;
  endtask

  int g;
  int seq [4];
  bit pend [2];
  logic [3:0] legal_ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8};

  initial begin
    bus.req_valid = 0; bus.rsp_ready = 0;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ADD
    set_req(0, 4'd2, 32'd5, 32'd7);
    cycle(2'b01, 2'b11, g);
    chk("t1_grant", 64'(g), 64'd0);
    #1;
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_result", 64'(bus.rsp_result), 64'd12);
    chk("t1_rsp_zero", 64'(bus.rsp_zero), 64'd0);

    // 2/6: contested for 4 cycles
    set_req(0, 4'd7, 32'h1234, 32'h00FF);
    set_req(1, 4'd1, 32'h0F00, 32'h000F);
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b11, seq[i]);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t6_fixed_grant", 64'(seq[i]), 64'd0);
`else
      chk("t2_rr_grant", 64'(seq[i]), 64'(i % 2));
`endif
    end

    // 3: backpressure on port 1 response
    cycle(2'b00, 2'b11, g);
    set_req(1, 4'd6, 32'd9, 32'd9);
    cycle(2'b10, 2'b11, g);
    set_req(0, 4'd2, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, 2'b01, g);
      chk("t3_stall", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      chk("t3_held_result", 64'(bus.rsp_result), 64'd0);
      chk("t3_held_zero", 64'(bus.rsp_zero), 64'd1);
    end
    cycle(2'b01, 2'b10, g);
    chk("t3_consume_grant", 64'(g), 64'd0);

    // 4: illegal then legal op
    set_req(0, 4'hF, 32'h55, 32'hAA);
    cycle(2'b01, 2'b11, g);
    #1;
    chk("t4_err", 64'(bus.rsp_err), 64'd1);
    chk("t4_err_result", 64'(bus.rsp_result), 64'd0);
    set_req(0, 4'd1, 32'hF0, 32'h0F);
    cycle(2'b01, 2'b11, g);
    #1;
    chk("t4_or_result", 64'(bus.rsp_result), 64'hFF);
    chk("t4_or_err", 64'(bus.rsp_err), 64'd0);

    // 5: reset while port 1 holds a response
    set_req(1, 4'd2, 32'd3, 32'd4);
    cycle(2'b10, 2'b11, g);
    cycle(2'b00, 2'b00, g);
    @(negedge clk);
    check_rsp();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.rsp_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(0, 4'd0, 32'hFF, 32'h0F);
    set_req(1, 4'd7, 32'h1, 32'h1);
    cycle(2'b11, 2'b11, g);
    chk("t5_post_rst_grant", 64'(g), 64'd0);

    // Random traffic; unaccepted requests are held unchanged
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] v;
      logic [1:0] rr;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 3) != 0)) begin
          logic [3:0] op;
          logic [31:0] a;
          op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
          a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          set_req(p, op, a, ($urandom_range(0, 3) == 0) ? a : $urandom);
          pend[p] = 1;
        end
      end
      v  = {pend[1], pend[0]};
      rr = 2'($urandom_range(0, 3));
      cycle(v, rr, g);
      if (g >= 0) pend[g] = 0;
    end
    cycle(2'b00, 2'b11, g);
    cycle(2'b00, 2'b11, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
